keypad_digit_buffer: RTL and testbench
======================================

Name: keypad_digit_buffer

Overview:
Downstream consumer of the keypad scanner's held-key output (valid flag plus latched row/column one-hot pair). Qualifies each press over several clock_new ticks and encodes it to a hex nibble. Applies edit keys (clear, backspace) and shifts digit keys into a 4-digit entry register. Time-multiplexes that register onto the 4-anode seven-segment display; ssd_driver decodes seg_code to the cathodes.

Parameters:
DEBOUNCE_CYCLES, 2, consecutive ticks an identical valid row/col pair must persist before acceptance (1..15)
RELEASE_CYCLES, 2, consecutive ticks key_valid must be low before re-arming (1..15)
REFRESH_DIV, 1, clock_new ticks each anode stays active (1..255)
CLEAR_CODE, 4'hC, key code that clears the buffer
BACK_CODE, 4'hB, key code that deletes the newest digit

Ports:
clock_new  input  1  scan-domain clock (posedge)
reset  input  1  asynchronous, active-high
key_valid  input  1  high while scanner holds a detected key
row  input  4  latched row lines, one-hot expected
col  input  4  latched driven column, one-hot expected
key_code  output  4  code of last accepted key
key_strobe  output  1  one-tick pulse on each accepted key
key_error  output  1  one-tick pulse when a non-one-hot row/col is qualified
digits  output  16  entry register; [3:0] newest
digit_count  output  3  number of entered digits, 0..4
AN  output  4  anode enables, active-low
seg_code  output  4  nibble for the currently enabled anode

Behaviour:
- Reset, async: all outputs 0 except AN=4'b1111. FSM=IDLE. Refresh counter=0. Anode index=0.
- Encoding: r = row bit index, c = col bit index.
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
  - Pure function of the one-hot pair.
- FSM (one transition per clock_new posedge):
  - IDLE: key_valid=1 -> QUAL; capture row/col; qual_cnt=1.
  - QUAL:
    - key_valid=0 -> IDLE.
    - row/col differ from captured -> recapture; qual_cnt=1.
    - Else qual_cnt++. When qual_cnt reaches DEBOUNCE_CYCLES: accept -> HELD.
  - HELD: key_valid=0 -> RELEASE; rel_cnt=1.
  - RELEASE:
    - key_valid=1 -> HELD; no new acceptance.
    - Else rel_cnt++. When rel_cnt reaches RELEASE_CYCLES -> IDLE.
  - With DEBOUNCE_CYCLES=1, acceptance occurs on the IDLE->QUAL tick itself. Same for RELEASE_CYCLES=1 on the HELD->RELEASE tick.
- Acceptance, with captured pair one-hot:
  - key_code updates; key_strobe=1 for exactly one tick.
  - Edit action applies on the same edge.
- Acceptance, with row or col not one-hot (0 or multiple bits):
  - key_error pulses one tick.
  - No strobe; key_code, digits and count unchanged.
  - FSM still goes to HELD.
- Edit actions:
  - CLEAR_CODE: digits=0, count=0.
  - BACK_CODE: digits>>=4 (zero-fill from the top); count=max(count-1,0).
  - Any other code: digits={digits[11:0],code}; count=min(count+1,4). The oldest digit is discarded when count was 4.
  - CLEAR_CODE/BACK_CODE never enter the buffer.
  - If CLEAR_CODE==BACK_CODE, clear wins.
- Display:
  - The refresh counter counts 0..REFRESH_DIV-1.
  - On wrap, the anode index advances 0->1->2->3->0.
  - AN[i]=0 only when index==i and i<digit_count; otherwise 1.
  - seg_code=digits[4i+3:4i] for the current index.
  - Display outputs are registered, one tick behind the buffer.
- Reset mid-press: buffer is lost; the still-held key is re-qualified from IDLE after reset and accepted again.

Test Plan:
- Reset (DEBOUNCE_CYCLES=2): key_valid=1, row=0001, col=0010 for 5 ticks -> exactly one key_strobe, on the 2nd tick. key_code=4'h2, digits=16'h0002, count=1.
- Bounce: valid on 1 tick, low 1 tick, valid 1 tick, low -> no strobe. Same pair held for 2 ticks afterwards -> one strobe.
- Pair change in QUAL: (r0,c0) for 1 tick, then (r1,c1) for 2 ticks -> single strobe with key_code=4'h5, not 4'h1.
- Enter keys 1,2,3,4,5, each with a full release -> digits=16'h2345, count=4. Then BACK_CODE -> digits=16'h0234, count=3. Then CLEAR_CODE -> digits=0, count=0, AN stays 4'b1111.
- Invalid pair row=0011, col=0001 held 2 ticks -> key_error pulse, no strobe, digits unchanged. Release then press (r3,c0) -> key_code=4'h0, count increments.
- Display with count=2, digits=16'h0047, REFRESH_DIV=1 -> AN cycles 1110, 1101, 1111, 1111. seg_code is 7 then 4. Async reset mid-cycle -> AN=1111 immediately.

Source files
------------

// File: rtl/keypad_digit_buffer.sv
// keypad_digit_buffer
//   Qualifies held keys from the keypad scanner, encodes each accepted press
//   to a hex nibble, applies clear/backspace edits to a 4-digit entry
//   register, and time-multiplexes that register onto a 4-anode display.
//
// Ports:
//   clock_new    in   1   scan-domain clock (posedge)
//   reset        in   1   asynchronous, active-high
//   key_valid    in   1   scanner holds a detected key
//   row          in   4   latched row lines, one-hot expected
//   col          in   4   latched driven column, one-hot expected
//   key_code     out  4   code of last accepted key
//   key_strobe   out  1   one-tick pulse per accepted key
//   key_error    out  1   one-tick pulse when a non-one-hot pair is qualified
//   digits       out  16  entry register, [3:0] newest
//   digit_count  out  3   number of entered digits, 0..4
//   AN           out  4   anode enables, active-low
//   seg_code     out  4   nibble for the currently enabled anode
module keypad_digit_buffer #(
   parameter int unsigned DEBOUNCE_CYCLES = 2,
   parameter int unsigned RELEASE_CYCLES  = 2,
   parameter int unsigned REFRESH_DIV     = 1,
   parameter logic [3:0]  CLEAR_CODE      = 4'hC,
   parameter logic [3:0]  BACK_CODE       = 4'hB
) (
   input  logic        clock_new,
   input  logic        reset,
   input  logic        key_valid,
   input  logic [3:0]  row,
   input  logic [3:0]  col,
   output logic [3:0]  key_code,
   output logic        key_strobe,
   output logic        key_error,
   output logic [15:0] digits,
   output logic [2:0]  digit_count,
   output logic [3:0]  AN,
   output logic [3:0]  seg_code
);

   localparam logic [3:0] DEB_LAST     = 4'(DEBOUNCE_CYCLES);
   localparam logic [3:0] REL_LAST     = 4'(RELEASE_CYCLES);
   localparam logic [7:0] REFRESH_LAST = 8'(REFRESH_DIV - 1);

   typedef enum logic [1:0] {IDLE, QUAL, HELD, RELEASE} state_t;

   state_t      state, state_next;
   logic [3:0]  cap_row, cap_col, cap_row_next, cap_col_next;
   logic [3:0]  qual_cnt, qual_cnt_next;
   logic [3:0]  rel_cnt, rel_cnt_next;
   logic        accept;
   logic        pair_ok;
   logic [3:0]  new_code;
   logic [7:0]  refresh_cnt;
   logic [1:0]  anode_idx;
   logic [3:0]  an_next;

   function automatic logic is_onehot(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

   function automatic logic [1:0] bit_index(input logic [3:0] v);
      case (v)
         4'b0001: return 2'd0;
         4'b0010: return 2'd1;
         4'b0100: return 2'd2;
         default: return 2'd3;
      endcase
   endfunction

   // Keypad legend, row-major.
   function automatic logic [3:0] encode(input logic [1:0] r, input logic [1:0] c);
      case ({r, c})
         4'h0: return 4'h1;  4'h1: return 4'h2;  4'h2: return 4'h3;  4'h3: return 4'hA;
         4'h4: return 4'h4;  4'h5: return 4'h5;  4'h6: return 4'h6;  4'h7: return 4'hB;
         4'h8: return 4'h7;  4'h9: return 4'h8;  4'hA: return 4'h9;  4'hB: return 4'hC;
         4'hC: return 4'h0;  4'hD: return 4'hF;  4'hE: return 4'hE;  default: return 4'hD;
      endcase
   endfunction

   // On an acceptance edge the live pair always equals the captured pair,
   // so the live inputs are encoded directly.
   assign pair_ok  = is_onehot(row) && is_onehot(col);
   assign new_code = encode(bit_index(row), bit_index(col));

   always_ff @(posedge clock_new or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cap_row  <= 4'd0;
         cap_col  <= 4'd0;
         qual_cnt <= 4'd0;
         rel_cnt  <= 4'd0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         state    <= state_next;
         cap_row  <= cap_row_next;
         cap_col  <= cap_col_next;
         qual_cnt <= qual_cnt_next;
         rel_cnt  <= rel_cnt_next;
      end
   end

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_next    = state;
      cap_row_next  = cap_row;
      cap_col_next  = cap_col;
      qual_cnt_next = qual_cnt;
      rel_cnt_next  = rel_cnt;
      accept        = 1'b0;
      case (state)
         IDLE: begin
            if (key_valid) begin
               cap_row_next  = row;
               cap_col_next  = col;
               qual_cnt_next = 4'd1;
               if (DEB_LAST == 4'd1) begin
                  accept     = 1'b1;
                  state_next = HELD;
               end else begin
                  state_next = QUAL;
               end
            end
         end
         QUAL: begin
            if (!key_valid) begin
               state_next = IDLE;
            end else if (row != cap_row || col != cap_col) begin
               cap_row_next  = row;
               cap_col_next  = col;
               qual_cnt_next = 4'd1;
            end else begin
               qual_cnt_next = qual_cnt + 4'd1;
               if (qual_cnt + 4'd1 == DEB_LAST) begin
                  accept     = 1'b1;
                  state_next = HELD;
               end
            end
         end
         HELD: begin
            if (!key_valid) begin
               rel_cnt_next = 4'd1;
               state_next   = (REL_LAST == 4'd1) ? IDLE : RELEASE;
            end
         end
         RELEASE: begin
            if (key_valid) begin
               state_next = HELD;
            end else begin
               rel_cnt_next = rel_cnt + 4'd1;
               if (rel_cnt + 4'd1 == REL_LAST) state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Entry register and key reporting.
   always_ff @(posedge clock_new or posedge reset) begin
      if (reset) begin
         key_code    <= 4'd0;
         key_strobe  <= 1'b0;
         key_error   <= 1'b0;
         digits      <= 16'd0;
         digit_count <= 3'd0;
      end else begin
         key_strobe <= 1'b0;
         key_error  <= 1'b0;
         if (accept) begin
            if (pair_ok) begin
               key_code   <= new_code;
               key_strobe <= 1'b1;
               // Clear is tested first so it wins if both codes coincide.
               if (new_code == CLEAR_CODE) begin
                  digits      <= 16'd0;
                  digit_count <= 3'd0;
               end else if (new_code == BACK_CODE) begin
                  digits      <= {4'd0, digits[15:4]};
                  digit_count <= (digit_count == 3'd0) ? 3'd0 : digit_count - 3'd1;
               end else begin
                  digits      <= {digits[11:0], new_code};
                  digit_count <= (digit_count == 3'd4) ? 3'd4 : digit_count + 3'd1;
               end
            end else begin
               key_error <= 1'b1;
            end
         end
      end
   end

   // Only anodes holding an entered digit are lit.
   always_comb begin
      an_next = 4'b1111;
      if ({1'b0, anode_idx} < digit_count) an_next[anode_idx] = 1'b0;
   end

   always_ff @(posedge clock_new or posedge reset) begin
      if (reset) begin
         refresh_cnt <= 8'd0;
         anode_idx   <= 2'd0;
         AN          <= 4'b1111;
         seg_code    <= 4'd0;
      end else begin
         if (refresh_cnt == REFRESH_LAST) begin
            refresh_cnt <= 8'd0;
            anode_idx   <= anode_idx + 2'd1;
         end else begin
            refresh_cnt <= refresh_cnt + 8'd1;
         end
         AN       <= an_next;
         seg_code <= digits[{anode_idx, 2'b00} +: 4];
      end
   end

endmodule

// File: tb/tb_keypad_digit_buffer.sv
module tb_keypad_digit_buffer;

   localparam int DEB = 2;
   localparam int REL = 2;
   localparam int REFRESH_DIV = 1;
   localparam logic [3:0] CLEAR_CODE = 4'hC;
   localparam logic [3:0] BACK_CODE  = 4'hB;
   localparam logic [3:0] KEY_MAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                           4'h4, 4'h5, 4'h6, 4'hB,
                                           4'h7, 4'h8, 4'h9, 4'hC,
                                           4'h0, 4'hF, 4'hE, 4'hD};

   logic        clock_new = 1'b0;
   logic        reset;
   logic        key_valid;
   logic [3:0]  row, col;
   logic [3:0]  key_code;
   logic        key_strobe, key_error;
   logic [15:0] digits;
   logic [2:0]  digit_count;
   logic [3:0]  AN, seg_code;

   int n_checks = 0;
   int n_fail   = 0;
   int tick_no  = 0;
   int strobes_obs = 0;
   int errors_obs  = 0;
   int last_strobe_tick = 0;

   // Reference model: a key is accepted once an identical valid pair has been
   // seen on DEB consecutive ticks while armed; re-armed after REL low ticks.
   bit         m_armed;
   int         m_run, m_low, m_tick;
   logic [3:0] m_prow, m_pcol, m_code;
   logic [3:0] m_q[$];   // entered digits, oldest first
   logic       m_strobe, m_err;
   logic [3:0] exp_an, exp_seg;

   keypad_digit_buffer #(
      .DEBOUNCE_CYCLES(DEB), .RELEASE_CYCLES(REL), .REFRESH_DIV(REFRESH_DIV),
      .CLEAR_CODE(CLEAR_CODE), .BACK_CODE(BACK_CODE)
   ) dut (
      .clock_new(clock_new), .reset(reset), .key_valid(key_valid),
      .row(row), .col(col), .key_code(key_code), .key_strobe(key_strobe),
      .key_error(key_error), .digits(digits), .digit_count(digit_count),
      .AN(AN), .seg_code(seg_code)
   );

   always #5 clock_new = ~clock_new;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1);
   end

   function automatic logic [15:0] model_digits();
      logic [15:0] d = 16'd0;
      foreach (m_q[i]) d = {d[11:0], m_q[i]};
      return d;
   endfunction

   task automatic model_reset();
      m_armed = 1; m_run = 0; m_low = 0; m_tick = 0;
      m_prow = 0; m_pcol = 0; m_code = 0; m_q.delete();
      m_strobe = 0; m_err = 0;
   endtask

   task automatic model_step(input logic v, input logic [3:0] r, input logic [3:0] c);
      int idx, ri, ci;
      idx = (m_tick / REFRESH_DIV) % 4;
      exp_an  = 4'b1111;
      exp_seg = 4'h0;
      if (idx < m_q.size()) begin
         exp_an[idx] = 1'b0;
         exp_seg = m_q[m_q.size() - 1 - idx];
      end
      m_tick++;
      m_strobe = 0;
      m_err = 0;
      if (m_armed) begin
         if (v) begin
            if (m_run > 0 && r == m_prow && c == m_pcol) m_run++;
            else m_run = 1;
            m_prow = r;
            m_pcol = c;
            if (m_run >= DEB) begin
               m_armed = 0; m_run = 0; m_low = 0;
               if ($countones(r) == 1 && $countones(c) == 1) begin
                  ri = 0; ci = 0;
                  for (int i = 0; i < 4; i++) begin
                     if (r[i]) ri = i;
                     if (c[i]) ci = i;
                  end
                  m_code = KEY_MAP[ri * 4 + ci];
                  m_strobe = 1;
                  if (m_code == CLEAR_CODE) m_q.delete();
                  else if (m_code == BACK_CODE) begin
                     if (m_q.size() > 0) void'(m_q.pop_back());
                  end else begin
                     m_q.push_back(m_code);
                     if (m_q.size() > 4) void'(m_q.pop_front());
                  end
               end else begin
                  m_err = 1;
               end
            end
         end else begin
            m_run = 0;
         end
      end else begin
         if (!v) begin
            m_low++;
            if (m_low >= REL) m_armed = 1;
         end else begin
            m_low = 0;
         end
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] r, input logic [3:0] c);
      key_valid = v; row = r; col = c;
      @(posedge clock_new);
      model_step(v, r, c);
      #1;
      tick_no++;
      if (key_strobe === 1'b1) begin strobes_obs++; last_strobe_tick = tick_no; end
      if (key_error === 1'b1) errors_obs++;
   endtask

   task automatic press(input int r, input int c);
      repeat (DEB + 1) drive(1'b1, 4'(1 << r), 4'(1 << c));
      repeat (REL + 1) drive(1'b0, 4'd0, 4'd0);
   endtask

   task automatic do_reset();
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      @(negedge clock_new);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      key_valid = 0; row = 0; col = 0;
      reset = 1'b1;
      #1;
      model_reset();
      n_checks++;
      if ({key_code, key_strobe, key_error, digits, digit_count, seg_code} !== 30'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got code=%h stb=%b err=%b dig=%h cnt=%0d seg=%h required all zero",
                  key_code, key_strobe, key_error, digits, digit_count, seg_code);
      end
      n_checks++;
      if (AN !== 4'b1111) begin
         n_fail++; $display("FAIL reset_an: got %b required 1111", AN);
      end
      @(negedge clock_new);
      reset = 1'b0;
   endtask

   task automatic test_basic_press();
      int s0, t0;
      s0 = strobes_obs; t0 = tick_no;
      repeat (5) drive(1'b1, 4'b0001, 4'b0010);
      n_checks++;
      if (strobes_obs - s0 != 1) begin
         n_fail++; $display("FAIL basic_strobe_count: got %0d required 1", strobes_obs - s0);
      end
      n_checks++;
      if (last_strobe_tick - t0 != 2) begin
         n_fail++; $display("FAIL basic_strobe_tick: got %0d required 2", last_strobe_tick - t0);
      end
      n_checks++;
      if (key_code !== 4'h2 || digits !== 16'h0002 || digit_count !== 3'd1) begin
         n_fail++;
         $display("FAIL basic_state: got code=%h dig=%h cnt=%0d required 2/0002/1", key_code, digits, digit_count);
      end
      repeat (REL + 1) drive(1'b0, 4'd0, 4'd0);
   endtask

   task automatic test_bounce();
      int s0;
      s0 = strobes_obs;
      drive(1'b1, 4'b0100, 4'b0001);
      drive(1'b0, 4'd0, 4'd0);
      drive(1'b1, 4'b0100, 4'b0001);
      drive(1'b0, 4'd0, 4'd0);
      n_checks++;
      if (strobes_obs != s0) begin
         n_fail++; $display("FAIL bounce_no_strobe: got %0d strobes required 0", strobes_obs - s0);
      end
      repeat (2) drive(1'b1, 4'b0100, 4'b0001);
      n_checks++;
      if (strobes_obs - s0 != 1 || key_code !== 4'h7) begin
         n_fail++;
         $display("FAIL bounce_accept: got %0d strobes code=%h required 1 strobe code=7", strobes_obs - s0, key_code);
      end
      repeat (REL + 1) drive(1'b0, 4'd0, 4'd0);
   endtask

   task automatic test_pair_change();
      int s0;
      s0 = strobes_obs;
      drive(1'b1, 4'b0001, 4'b0001);
      repeat (2) drive(1'b1, 4'b0010, 4'b0010);
      n_checks++;
      if (strobes_obs - s0 != 1 || key_code !== 4'h5) begin
         n_fail++;
         $display("FAIL pair_change: got %0d strobes code=%h required 1 strobe code=5", strobes_obs - s0, key_code);
      end
      repeat (REL + 1) drive(1'b0, 4'd0, 4'd0);
   endtask

   task automatic test_entry_edit();
      do_reset();
      press(0, 0); press(0, 1); press(0, 2); press(1, 0); press(1, 1);
      n_checks++;
      if (digits !== 16'h2345 || digit_count !== 3'd4) begin
         n_fail++; $display("FAIL entry_five: got dig=%h cnt=%0d required 2345/4", digits, digit_count);
      end
      press(1, 3);
      n_checks++;
      if (digits !== 16'h0234 || digit_count !== 3'd3 || key_code !== BACK_CODE) begin
         n_fail++;
         $display("FAIL entry_back: got dig=%h cnt=%0d code=%h required 0234/3/B", digits, digit_count, key_code);
      end
      press(2, 3);
      n_checks++;
      if (digits !== 16'h0000 || digit_count !== 3'd0 || key_code !== CLEAR_CODE) begin
         n_fail++;
         $display("FAIL entry_clear: got dig=%h cnt=%0d code=%h required 0000/0/C", digits, digit_count, key_code);
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 4'd0, 4'd0);
         n_checks++;
         if (AN !== 4'b1111) begin
            n_fail++; $display("FAIL entry_clear_an[%0d]: got %b required 1111", i, AN);
         end
      end
   endtask

   task automatic test_invalid_pair();
      int s0, e0;
      press(2, 2);
      s0 = strobes_obs; e0 = errors_obs;
      repeat (2) drive(1'b1, 4'b0011, 4'b0001);
      n_checks++;
      if (errors_obs - e0 != 1 || strobes_obs != s0) begin
         n_fail++;
         $display("FAIL invalid_pulse: got err=%0d stb=%0d required err=1 stb=0", errors_obs - e0, strobes_obs - s0);
      end
      n_checks++;
      if (digits !== 16'h0009 || digit_count !== 3'd1 || key_code !== 4'h9) begin
         n_fail++;
         $display("FAIL invalid_hold: got dig=%h cnt=%0d code=%h required 0009/1/9", digits, digit_count, key_code);
      end
      repeat (REL + 1) drive(1'b0, 4'd0, 4'd0);
      press(3, 0);
      n_checks++;
      if (key_code !== 4'h0 || digit_count !== 3'd2 || digits !== 16'h0090) begin
         n_fail++;
         $display("FAIL invalid_recover: got code=%h cnt=%0d dig=%h required 0/2/0090", key_code, digit_count, digits);
      end
   endtask

   task automatic test_display();
      int n_a, n_b, n_off;
      do_reset();
      press(1, 0); press(2, 0);
      n_checks++;
      if (digits !== 16'h0047 || digit_count !== 3'd2) begin
         n_fail++; $display("FAIL display_setup: got dig=%h cnt=%0d required 0047/2", digits, digit_count);
      end
      n_a = 0; n_b = 0; n_off = 0;
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 4'd0, 4'd0);
         n_checks++;
         if (AN !== exp_an || (AN != 4'b1111 && seg_code !== exp_seg)) begin
            n_fail++;
            $display("FAIL display_tick[%0d]: got AN=%b seg=%h required AN=%b seg=%h", i, AN, seg_code, exp_an, exp_seg);
         end
         if (AN == 4'b1110 && seg_code == 4'h7) n_a++;
         if (AN == 4'b1101 && seg_code == 4'h4) n_b++;
         if (AN == 4'b1111) n_off++;
      end
      n_checks++;
      if (n_a != 2 || n_b != 2 || n_off != 4) begin
         n_fail++;
         $display("FAIL display_rotation: got an0=%0d an1=%0d off=%0d required 2/2/4", n_a, n_b, n_off);
      end
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if (AN !== 4'b1111 || digits !== 16'h0000) begin
         n_fail++; $display("FAIL display_async_reset: got AN=%b dig=%h required 1111/0000", AN, digits);
      end
      model_reset();
      @(negedge clock_new);
      reset = 1'b0;
   endtask

   task automatic test_reset_mid_press();
      int s0;
      do_reset();
      press(0, 0); press(0, 1);
      repeat (3) drive(1'b1, 4'b0001, 4'b0100);
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if (digits !== 16'h0000 || digit_count !== 3'd0 || key_code !== 4'h0) begin
         n_fail++;
         $display("FAIL midpress_reset: got dig=%h cnt=%0d code=%h required 0000/0/0", digits, digit_count, key_code);
      end
      model_reset();
      @(negedge clock_new);
      reset = 1'b0;
      s0 = strobes_obs;
      repeat (3) drive(1'b1, 4'b0001, 4'b0100);
      n_checks++;
      if (strobes_obs - s0 != 1 || key_code !== 4'h3 || digits !== 16'h0003 || digit_count !== 3'd1) begin
         n_fail++;
         $display("FAIL midpress_requal: got stb=%0d code=%h dig=%h cnt=%0d required 1/3/0003/1",
                  strobes_obs - s0, key_code, digits, digit_count);
      end
      repeat (REL + 1) drive(1'b0, 4'd0, 4'd0);
   endtask

   task automatic test_random();
      logic [8:0] stim[$];   // {valid, row, col}
      int k, hold, low;
      logic [3:0] r, c;
      do_reset();
      for (int seg = 0; seg < 70; seg++) begin
         k = $urandom_range(0, 15);
         r = 4'(1 << (k / 4));
         c = 4'(1 << (k % 4));
         if ($urandom_range(0, 9) == 0) r = r | 4'(1 << (((k / 4) + 1) % 4));
         hold = $urandom_range(1, 4);
         for (int h = 0; h < hold; h++) begin
            if ($urandom_range(0, 7) == 0) c = 4'(1 << $urandom_range(0, 3));
            stim.push_back({1'b1, r, c});
         end
         low = $urandom_range(1, 3);
         for (int l = 0; l < low; l++) stim.push_back(9'd0);
      end
      foreach (stim[i]) begin
         drive(stim[i][8], stim[i][7:4], stim[i][3:0]);
         n_checks++;
         if (key_strobe !== m_strobe || key_error !== m_err) begin
            n_fail++;
            $display("FAIL rand_pulse[%0d]: got stb=%b err=%b required stb=%b err=%b", i, key_strobe, key_error, m_strobe, m_err);
         end
         n_checks++;
         if (key_code !== m_code) begin
            n_fail++; $display("FAIL rand_code[%0d]: got %h required %h", i, key_code, m_code);
         end
         n_checks++;
         if (digits !== model_digits() || digit_count !== 3'(m_q.size())) begin
            n_fail++;
            $display("FAIL rand_buffer[%0d]: got dig=%h cnt=%0d required dig=%h cnt=%0d",
                     i, digits, digit_count, model_digits(), m_q.size());
         end
         n_checks++;
         if (AN !== exp_an || seg_code !== exp_seg) begin
            n_fail++;
            $display("FAIL rand_display[%0d]: got AN=%b seg=%h required AN=%b seg=%h", i, AN, seg_code, exp_an, exp_seg);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_press();
      test_bounce();
      test_pair_change();
      test_entry_edit();
      test_invalid_pair();
      test_display();
      test_reset_mid_press();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
